reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised successor of the 16x16 processor register file. It has two registered read ports, one write port and a per-register pending-write scoreboard. A reset-triggered clear sequencer zeroes the array one entry per cycle. It sits between decode/issue (reads, reservations) and writeback (Load) in the pipelined datapath.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; NUM_REGS = 2**ADDR_W
- ZERO_R0, 0, 1 = register 0 is hardwired zero: writes and reservations to it are dropped, reads return 0, ready is 1
- clk  input  1  single clock, rising edge
- Clear  input  1  synchronous, active-high reset; starts the clear sweep
- Aaddr  input  ADDR_W  read port A address
- Baddr  input  ADDR_W  read port B address
- A  output  DATA_W  registered read data, port A
- B  output  DATA_W  registered read data, port B
- A_rdy  output  1  registered; 1 = no pending write on the register read via A
- B_rdy  output  1  registered; 1 = no pending write on the register read via B
- Caddr  input  ADDR_W  write address
- C  input  DATA_W  write data
- Load  input  1  write enable
- Rsv  input  1  reserve the register at Rsv_addr, setting its pending bit
- Rsv_addr  input  ADDR_W  reservation address
- Busy  output  1  1 while the clear sweep is active

## Operation
- FSM states:
  - IDLE: normal operation.
  - SWEEP: one register zeroed per cycle, using pointer ptr.
- Clear sampled high, in any state:
  - ptr <= 0, state <= SWEEP.
  - All pending bits <= 0.
  - A, B <= 0; A_rdy, B_rdy <= 0; Busy <= 1.
  - A Clear arriving mid-sweep restarts the sweep at 0.
- SWEEP, each edge:
  - reg[ptr] <= 0, ptr <= ptr+1.
  - On the edge that clears reg[NUM_REGS-1]: state <= IDLE, Busy <= 0.
- While Busy=1 or Clear=1:
  - Load and Rsv are ignored.
  - A, B, A_rdy and B_rdy are held at 0.
- IDLE write: when Load=1, reg[Caddr] <= C and pending[Caddr] <= 0.
- IDLE reserve: when Rsv=1, pending[Rsv_addr] <= 1.
- Load and Rsv to the same address on the same edge: the reservation wins, so the bit ends at 1 and the data is still written.
- IDLE read, each edge: A <= reg[Aaddr] and A_rdy <= ~pending[Aaddr], using pre-edge state. Port B behaves the same.
- Aaddr == Baddr is legal; both ports return identical data.
- ZERO_R0=1: reg[0] is never written and reads return 0.
- No arithmetic is performed; all indices are unsigned and ptr is ADDR_W+1 bits wide.

## Timing
- Read latency is 1 cycle: an address presented before edge n yields data valid after edge n.
- A write takes effect at the edge where Load is sampled and is visible to reads at the following edge.
- Read of the register being written on the same edge (no bypass): the old value is returned, with A_rdy from the pre-edge pending bit.
- Sweep length: Busy is high for exactly NUM_REGS cycles after the edge that samples a single-cycle Clear, and stays high for as long as Clear is held.
- Power-up contents are undefined until the first Clear completes.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If Load=1 with Caddr == Aaddr on the same IDLE edge, A <= C and A_rdy <= 1. Port B behaves the same.
  - This holds unless a same-edge Rsv targets that address, in which case rdy <= 0.
  - ZERO_R0 still forces 0 for address 0.
- Undefined: no forwarding; the same-edge read returns the old value as described in Timing.

## Test plan
- Sweep:
  - Stimulus: Clear pulse for one cycle, defaults.
  - Required: Busy=1 for 16 cycles then 0; A=B=0 and A_rdy=B_rdy=0 during the sweep; afterwards every register reads 0x0000 with rdy=1.
- Write/read:
  - Stimulus: Load with Caddr=5, C=0xBEEF; next cycle Aaddr=5, Baddr=5.
  - Required: one cycle later A=B=0xBEEF.
- Same-edge hazard:
  - Stimulus: reg 3 = 0x1111; Load 3 with 0x2222 while Aaddr=3.
  - Required: A=0x1111 without the macro, A=0x2222 with REGFILE_BYPASS_EN.
- Scoreboard:
  - Stimulus: Rsv 7, then read 7, then Load 7 with 0x00AA, then read 7.
  - Required: A_rdy=0 on the first read; A_rdy=1 and A=0x00AA on the second.
  - Stimulus: Rsv and Load to 7 on the same edge.
  - Required: the next read gives A_rdy=0 with the new data.
- Clear mid-sweep:
  - Stimulus: reassert Clear at sweep cycle 6; issue a Load during the sweep.
  - Required: Busy stays high for 16 further cycles; the Load is ignored and the register reads 0 afterwards.
- ZERO_R0=1:
  - Stimulus: Load 0 with 0xFFFF, Rsv 0, read 0.
  - Required: A=0x0000, A_rdy=1.

Source files
------------

// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: two read ports, one write port, reservation and sweep status.
// The master modport drives addresses/write data; the slave modport is the register file side.
interface reg_file_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] Aaddr;
  logic [ADDR_W-1:0] Baddr;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              A_rdy;
  logic              B_rdy;
  logic [ADDR_W-1:0] Caddr;
  logic [DATA_W-1:0] C;
  logic              Load;
  logic              Rsv;
  logic [ADDR_W-1:0] Rsv_addr;
  logic              Busy;

  modport master (
    output Aaddr, Baddr, Caddr, C, Load, Rsv, Rsv_addr,
    input  A, B, A_rdy, B_rdy, Busy
  );

  modport slave (
    input  Aaddr, Baddr, Caddr, C, Load, Rsv, Rsv_addr,
    output A, B, A_rdy, B_rdy, Busy
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with two registered read ports, one write port, a pending-write scoreboard
// and a Clear-triggered zeroing sweep. Define REGFILE_BYPASS_EN to forward same-edge writes.
module reg_file_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic          clk,
  input  logic          Clear,
  reg_file_sb_if.slave  bus
);
  localparam int              NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(NUM_REGS - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              r_state;
  logic [ADDR_W:0]     r_ptr;
  logic [NUM_REGS-1:0] r_pending;
  logic [DATA_W-1:0]   r_mem [NUM_REGS];

  logic              w_load_ok, w_rsv_ok;
  logic              w_a_zero, w_b_zero, w_a_fwd, w_b_fwd;
  logic [DATA_W-1:0] w_a_data, w_b_data;
  logic              w_a_rdy, w_b_rdy;

  assign w_load_ok = bus.Load && !(ZERO_R0 && bus.Caddr == '0);
  assign w_rsv_ok  = bus.Rsv  && !(ZERO_R0 && bus.Rsv_addr == '0);
  assign w_a_zero  = ZERO_R0 && bus.Aaddr == '0;
  assign w_b_zero  = ZERO_R0 && bus.Baddr == '0;

`ifdef REGFILE_BYPASS_EN
  assign w_a_fwd = w_load_ok && bus.Caddr == bus.Aaddr;
  assign w_b_fwd = w_load_ok && bus.Caddr == bus.Baddr;
`else
  assign w_a_fwd = 1'b0;
  assign w_b_fwd = 1'b0;
`endif

  // A forwarded write is ready unless a same-edge reservation re-marks it pending.
  assign w_a_data = w_a_zero ? '0 : (w_a_fwd ? bus.C : r_mem[bus.Aaddr]);
  assign w_b_data = w_b_zero ? '0 : (w_b_fwd ? bus.C : r_mem[bus.Baddr]);
  assign w_a_rdy  = w_a_zero | (w_a_fwd ? !(w_rsv_ok && bus.Rsv_addr == bus.Aaddr)
                                        : ~r_pending[bus.Aaddr]);
  assign w_b_rdy  = w_b_zero | (w_b_fwd ? !(w_rsv_ok && bus.Rsv_addr == bus.Baddr)
                                        : ~r_pending[bus.Baddr]);

  // NOTE: all state here uses non-blocking assignments so every read sees pre-edge values.
  // NOTE: r_mem is deliberately absent from the Clear branch; the sweep zeroes it one entry
  // per cycle so the array stays a plain RAM without a wide reset fan-out.
  always_ff @(posedge clk) begin
    if (Clear) begin
      r_state   <= SWEEP;
      r_ptr     <= '0;
      r_pending <= '0;
      bus.A     <= '0;
      bus.B     <= '0;
      bus.A_rdy <= 1'b0;
      bus.B_rdy <= 1'b0;
      bus.Busy  <= 1'b1;
    end else begin
      case (r_state)
        SWEEP: begin
          r_mem[r_ptr[ADDR_W-1:0]] <= '0;
          r_ptr     <= r_ptr + (ADDR_W + 1)'(1);
          bus.A     <= '0;
          bus.B     <= '0;
          bus.A_rdy <= 1'b0;
          bus.B_rdy <= 1'b0;
          if (r_ptr == LAST_PTR) begin
            r_state  <= IDLE;
            bus.Busy <= 1'b0;
          end
        end
        IDLE: begin
          // Reservation is assigned last so it wins over a same-address Load.
          if (w_load_ok) begin
            r_mem[bus.Caddr]     <= bus.C;
            r_pending[bus.Caddr] <= 1'b0;
          end
          if (w_rsv_ok) r_pending[bus.Rsv_addr] <= 1'b1;
          bus.A     <= w_a_data;
          bus.B     <= w_b_data;
          bus.A_rdy <= w_a_rdy;
          bus.B_rdy <= w_b_rdy;
          bus.Busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: sweep timing, read/write table, scoreboard,
// mid-sweep Clear and a ZERO_R0=1 instance sharing the same stimulus.
module tb_reg_file_sb;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic Clear = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  reg_file_sb_if #(.DATA_W(16), .ADDR_W(4)) b ();
  reg_file_sb_if #(.DATA_W(16), .ADDR_W(4)) bz ();

  reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1'b0)) dut (
    .clk(clk), .Clear(Clear), .bus(b.slave));
  reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1'b1)) dut_z (
    .clk(clk), .Clear(Clear), .bus(bz.slave));

  assign bz.Aaddr    = b.Aaddr;
  assign bz.Baddr    = b.Baddr;
  assign bz.Caddr    = b.Caddr;
  assign bz.C        = b.C;
  assign bz.Load     = b.Load;
  assign bz.Rsv      = b.Rsv;
  assign bz.Rsv_addr = b.Rsv_addr;

  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic [3:0]  caddr;
    logic [15:0] c;
    logic        rsv;
    logic [3:0]  raddr;
    logic [3:0]  aaddr;
    logic [3:0]  baddr;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        eardy;
    logic        ebrdy;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic load, input logic [3:0] caddr, input logic [15:0] c,
                              input logic rsv, input logic [3:0] raddr,
                              input logic [3:0] aaddr, input logic [3:0] baddr,
                              input logic [15:0] ea, input logic [15:0] eb,
                              input logic eardy, input logic ebrdy);
    vec_t v;
    v.load = load; v.caddr = caddr; v.c = c; v.rsv = rsv; v.raddr = raddr;
    v.aaddr = aaddr; v.baddr = baddr; v.ea = ea; v.eb = eb;
    v.eardy = eardy; v.ebrdy = ebrdy;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b.Load = 1'b0; b.Caddr = '0; b.C = '0;
    b.Rsv = 1'b0; b.Rsv_addr = '0;
    b.Aaddr = '0; b.Baddr = '0;
  endtask

  // Counts cycles with Busy high starting from the current one; outputs must stay zero.
  task automatic measure_busy(output int n);
    n = 0;
    while (b.Busy === 1'b1 && n < 64) begin
      check("sweep_outputs_zero", {30'd0, b.A, b.B, b.A_rdy, b.B_rdy}, 64'd0);
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    idle_inputs();

    // Power-up sweep.
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    check("busy_after_clear", b.Busy, 1);
    measure_busy(n);
    check("sweep_length", n, 16);
    check("busy_low_after_sweep", b.Busy, 0);

    // Every register reads zero and ready after the sweep.
    for (int i = 0; i < 16; i++) begin
      b.Aaddr = 4'(i);
      b.Baddr = 4'(15 - i);
      tick();
      check("post_sweep_read", {b.A, b.B, b.A_rdy, b.B_rdy}, {16'h0, 16'h0, 1'b1, 1'b1});
    end

    vecs[0]  = mk(1, 5, 16'hBEEF, 0, 0, 0, 1, 16'h0000, 16'h0000, 1, 1);
    vecs[1]  = mk(0, 0, 16'h0000, 0, 0, 5, 5, 16'hBEEF, 16'hBEEF, 1, 1);
    vecs[2]  = mk(1, 3, 16'h1111, 0, 0, 5, 5, 16'hBEEF, 16'hBEEF, 1, 1);
    vecs[3]  = mk(0, 0, 16'h0000, 0, 0, 3, 5, 16'h1111, 16'hBEEF, 1, 1);
    vecs[4]  = mk(1, 3, 16'h2222, 0, 0, 3, 5, BYP ? 16'h2222 : 16'h1111, 16'hBEEF, 1, 1);
    vecs[5]  = mk(0, 0, 16'h0000, 0, 0, 3, 3, 16'h2222, 16'h2222, 1, 1);
    vecs[6]  = mk(0, 0, 16'h0000, 1, 7, 7, 3, 16'h0000, 16'h2222, 1, 1);
    vecs[7]  = mk(0, 0, 16'h0000, 0, 0, 7, 7, 16'h0000, 16'h0000, 0, 0);
    vecs[8]  = mk(1, 7, 16'h00AA, 0, 0, 7, 9, BYP ? 16'h00AA : 16'h0000, 16'h0000, BYP, 1);
    vecs[9]  = mk(0, 0, 16'h0000, 0, 0, 7, 7, 16'h00AA, 16'h00AA, 1, 1);
    vecs[10] = mk(1, 7, 16'h0BB0, 1, 7, 2, 3, 16'h0000, 16'h2222, 1, 1);
    vecs[11] = mk(0, 0, 16'h0000, 0, 0, 7, 7, 16'h0BB0, 16'h0BB0, 0, 0);
    vecs[12] = mk(1, 7, 16'h1234, 0, 0, 7, 3, BYP ? 16'h1234 : 16'h0BB0, 16'h2222, BYP, 1);
    vecs[13] = mk(1, 4, 16'h4444, 1, 4, 4, 7, BYP ? 16'h4444 : 16'h0000, 16'h1234, !BYP, 1);
    vecs[14] = mk(0, 0, 16'h0000, 0, 0, 4, 7, 16'h4444, 16'h1234, 0, 1);
    vecs[15] = mk(1, 0, 16'hFFFF, 1, 0, 0, 4, BYP ? 16'hFFFF : 16'h0000, 16'h4444, !BYP, 0);
    vecs[16] = mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0);

    for (int i = 0; i < 17; i++) begin
      b.Load = vecs[i].load; b.Caddr = vecs[i].caddr; b.C = vecs[i].c;
      b.Rsv = vecs[i].rsv; b.Rsv_addr = vecs[i].raddr;
      b.Aaddr = vecs[i].aaddr; b.Baddr = vecs[i].baddr;
      tick();
      check($sformatf("vec%0d_data", i), {b.A, b.B}, {vecs[i].ea, vecs[i].eb});
      check($sformatf("vec%0d_rdy", i), {b.A_rdy, b.B_rdy}, {vecs[i].eardy, vecs[i].ebrdy});
      if (i >= 15)
        check($sformatf("zero_r0_vec%0d", i), {bz.A, bz.A_rdy}, {16'h0000, 1'b1});
    end
    idle_inputs();

    // Clear re-asserted at sweep cycle 6, with Load/Rsv attempted throughout.
    b.Load = 1'b1; b.Caddr = 4'd5; b.C = 16'h5555;
    b.Rsv = 1'b1; b.Rsv_addr = 4'd9;
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    repeat (5) tick();
    check("busy_before_reclear", b.Busy, 1);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    measure_busy(n);
    check("resweep_length", n, 16);
    idle_inputs();

    b.Aaddr = 4'd5; b.Baddr = 4'd3;
    tick();
    check("after_resweep_5_3", {b.A, b.B, b.A_rdy, b.B_rdy}, {16'h0, 16'h0, 1'b1, 1'b1});
    b.Aaddr = 4'd7; b.Baddr = 4'd9;
    tick();
    check("after_resweep_7_9", {b.A, b.B, b.A_rdy, b.B_rdy}, {16'h0, 16'h0, 1'b1, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
